// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller beside the decode stage.
// Detects load-use hazards between ID and a load in EX (stall + bubble),
// and flushes IF/ID on taken branches / jumps. Stall and flush responses
// are combinational (same cycle); multi-cycle stalls/flushes are tracked by
// a small RUN/STALL/FLUSH state machine with a 2-bit remaining-cycle count.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush event counters
// (ports stallCount, flushCount).
module hazard_ctrl #(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRt,
    input  logic [4:0]  exRt,
    input  logic        exMemRead,
    input  logic        branchTaken,
    input  logic        jump,
    output logic        stallPc,
    output logic        stallIfId,
    output logic        bubbleIdEx,
    output logic        flushIfId,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stallCount,
    output logic [15:0] flushCount,
`endif
    output logic        busy
);

    // Elaboration-time legality check of the cycle-count parameters.
    if (LOAD_STALL < 1 || LOAD_STALL > 4) begin : g_bad_load_stall
        $error("hazard_ctrl: LOAD_STALL=%0d outside 1..4", LOAD_STALL);
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
        $error("hazard_ctrl: FLUSH_CYCLES=%0d outside 1..4", FLUSH_CYCLES);
    end

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter reload values: the first stall/flush cycle is spent in RUN,
    // so the remaining-cycle count starts at N-2.
    localparam logic [1:0] STALL_RELOAD = (LOAD_STALL   > 1) ? 2'(LOAD_STALL - 2)   : 2'd0;
    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam bit         MULTI_STALL  = (LOAD_STALL   > 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t     r_state;
    logic [1:0] r_cnt;
    state_t     w_state_nxt;
    logic [1:0] w_cnt_nxt;
    logic       w_hz;
    logic       w_br;

    // Load-use hazard and control-flow change; $0 never creates a hazard.
    assign w_hz = exMemRead && (exRt != 5'd0) &&
                  ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
    assign w_br = branchTaken || jump;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; a branch always wins over a hazard.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned
        // (otherwise a latch is inferred).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            RUN: begin
                if (w_br) begin
                    if (MULTI_FLUSH) begin
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = FLUSH_RELOAD;
                    end
                end else if (w_hz) begin
                    if (MULTI_STALL) begin
                        w_state_nxt = STALL;
                        w_cnt_nxt   = STALL_RELOAD;
                    end
                end
            end
            STALL, FLUSH: begin
                if (w_br) begin
                    // A branch aborts a stall, or restarts an ongoing flush.
                    if (MULTI_FLUSH) begin
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = FLUSH_RELOAD;
                    end else begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = 2'd0;
                    end
                end else if (r_cnt == 2'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        stallPc    = 1'b0;
        stallIfId  = 1'b0;
        bubbleIdEx = 1'b0;
        flushIfId  = 1'b0;
        busy       = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                RUN: begin
                    if (w_br) begin
                        flushIfId = 1'b1;
                    end else if (w_hz) begin
                        stallPc    = 1'b1;
                        stallIfId  = 1'b1;
                        bubbleIdEx = 1'b1;
                    end
                end
                STALL: begin
                    busy = 1'b1;
                    if (w_br) begin
                        flushIfId = 1'b1;
                    end else begin
                        stallPc    = 1'b1;
                        stallIfId  = 1'b1;
                        bubbleIdEx = 1'b1;
                    end
                end
                FLUSH: begin
                    busy      = 1'b1;
                    flushIfId = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            if (stallPc && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (flushIfId && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stallCount = r_stall_count;
    assign flushCount = r_flush_count;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Several parameterisations share one
// set of inputs; each test resets everything and checks the instance whose
// parameters it targets. Output vectors are {stallPc, stallIfId,
// bubbleIdEx, flushIfId, busy}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] idRs, idRt, exRt;
    logic       idUsesRt, exMemRead, branchTaken, jump;

    wire [4:0] v11, v31, v22, v14, v21;
`ifdef HAZARD_STATS_EN
    wire [15:0] sc11, fc11, sc31, fc31, sc22, fc22, sc14, fc14, sc21, fc21;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
`define HC_STATS(sc, fc) .stallCount(sc), .flushCount(fc),
`else
`define HC_STATS(sc, fc)
`endif

`define HC_INST(name, ls, fcy, v, sc, fc) \
    hazard_ctrl #(.LOAD_STALL(ls), .FLUSH_CYCLES(fcy)) name ( \
        .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt), \
        .idUsesRt(idUsesRt), .exRt(exRt), .exMemRead(exMemRead), \
        .branchTaken(branchTaken), .jump(jump), \
        .stallPc(v[4]), .stallIfId(v[3]), .bubbleIdEx(v[2]), \
        .flushIfId(v[1]), `HC_STATS(sc, fc) .busy(v[0]));

    `HC_INST(u11, 1, 1, v11, sc11, fc11)
    `HC_INST(u31, 3, 1, v31, sc31, fc31)
    `HC_INST(u22, 2, 2, v22, sc22, fc22)
    `HC_INST(u14, 1, 4, v14, sc14, fc14)
    `HC_INST(u21, 2, 1, v21, sc21, fc21)

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic [4:0] ert, input logic mrd, input logic bt, input logic jp);
        idRs        = rs;
        idRt        = rt;
        idUsesRt    = uses;
        exRt        = ert;
        exMemRead   = mrd;
        branchTaken = bt;
        jump        = jp;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset forces outputs low even with a live hazard on the inputs.
        rst_n = 1'b0;
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        check("rst_c1_u11", {27'd0, v11}, 32'h0);
        check("rst_c1_u14", {27'd0, v14}, 32'h0);
        tick();
        check("rst_c2_u31", {27'd0, v31}, 32'h0);
        tick();
        rst_n = 1'b1;
        idle();
        check("run_idle_a", {27'd0, v11}, 32'h0);
        tick();
        check("run_idle_b", {27'd0, v11}, 32'h0);

        // 2: rs load-use, LOAD_STALL=1.
        do_reset();
        drive(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        check("rs_hz_c1", {27'd0, v11}, 32'h1C);
        tick();
        idle();
        check("rs_hz_c2", {27'd0, v11}, 32'h0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("r0_no_hz", {27'd0, v11}, 32'h0);
        tick();

        // 3: rt load-use, LOAD_STALL=3.
        do_reset();
        drive(5'd0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        check("rt_hz_c1", {27'd0, v31}, 32'h1C);
        tick();
        idle();
        check("rt_hz_c2", {27'd0, v31}, 32'h1D);
        tick();
        check("rt_hz_c3", {27'd0, v31}, 32'h1D);
        tick();
        check("rt_hz_c4", {27'd0, v31}, 32'h0);
        tick();
        drive(5'd0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        check("rt_unused", {27'd0, v31}, 32'h0);
        tick();

        // 4a: hazard and branch together, LOAD_STALL=2 FLUSH_CYCLES=2.
        do_reset();
        drive(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        check("br_hz_c1", {27'd0, v22}, 32'h02);
        tick();
        idle();
        check("br_hz_c2", {27'd0, v22}, 32'h03);
        tick();
        check("br_hz_c3", {27'd0, v22}, 32'h0);
        tick();

        // 4b: branch in the second stall cycle aborts the stall.
        drive(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        check("stall_ab_c1", {27'd0, v22}, 32'h1C);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("stall_ab_c2", {27'd0, v22}, 32'h03);
        tick();
        idle();
        check("stall_ab_c3", {27'd0, v22}, 32'h03);
        tick();
        check("stall_ab_c4", {27'd0, v22}, 32'h0);
        tick();

        // 5: reset in the middle of a 4-cycle flush.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("jmp_c1", {27'd0, v14}, 32'h02);
        tick();
        idle();
        check("jmp_c2", {27'd0, v14}, 32'h03);
        rst_n = 1'b0;
        #1;
        check("jmp_rst_now", {27'd0, v14}, 32'h0);
        tick();
        rst_n = 1'b1;
        idle();
        check("jmp_after_rst_a", {27'd0, v14}, 32'h0);
        tick();
        check("jmp_after_rst_b", {27'd0, v14}, 32'h0);
        tick();

        // 6: three 2-cycle stalls and one single-cycle flush.
        do_reset();
`ifdef HAZARD_STATS_EN
        check("stats_rst_stall", {16'd0, sc21}, 32'd0);
        check("stats_rst_flush", {16'd0, fc21}, 32'd0);
`endif
        for (int e = 0; e < 3; e++) begin
            drive(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
            check("ls2_ev_c1", {27'd0, v21}, 32'h1C);
            tick();
            idle();
            check("ls2_ev_c2", {27'd0, v21}, 32'h1D);
            tick();
            check("ls2_ev_c3", {27'd0, v21}, 32'h0);
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("fc1_br", {27'd0, v21}, 32'h02);
        tick();
        idle();
        check("fc1_after", {27'd0, v21}, 32'h0);
`ifdef HAZARD_STATS_EN
        check("stats_stall", {16'd0, sc21}, 32'd6);
        check("stats_flush", {16'd0, fc21}, 32'd1);
        do_reset();
        check("stats_clr_stall", {16'd0, sc21}, 32'd0);
        check("stats_clr_flush", {16'd0, fc21}, 32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
